instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset (0 = in reset).
REQ-005 SHALL have port imem_req  output  1  fetch request to program memory this cycle.
REQ-006 SHALL have port imem_addr  output  32  byte address of requested word.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid exactly one cycle after imem_req.
REQ-008 SHALL have port redirect  input  1  branch/jump taken; flush and restart.
REQ-009 SHALL have port redirect_pc  input  32  restart address, sampled when redirect=1.
REQ-010 SHALL have port out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-011 SHALL have port out_instr  output  32  head-of-queue instruction word.
REQ-012 SHALL have port out_pc  output  32  address of out_instr.
REQ-013 SHALL have port out_ready  input  1  downstream executor accepts head this cycle.
REQ-014 SHALL have port fetch_fault  output  1  misaligned redirect detected (see Configuration).

Function
REQ-015 SHALL issue imem_req=1 iff not in reset, fetch_fault=0, and (occupancy + in-flight) < DEPTH; in-flight is 0 or 1.
REQ-016 SHALL present imem_addr = fetch PC; fetch PC SHALL advance by 4 on each cycle imem_req=1 and no redirect.
REQ-017 SHALL write imem_rdata with its issuing address into the queue at the end of the cycle after the request unless squashed.
REQ-018 SHALL drive out_valid/out_instr/out_pc from queue registers only (no combinational path from imem_rdata); request in cycle N gives out_valid in cycle N+2 if queue was empty.
REQ-019 SHALL sustain one instruction per cycle while out_ready=1 and no redirect.
REQ-020 SHALL pop head on the clock edge where out_valid=1 and out_ready=1; out_instr/out_pc SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 SHALL never overflow: full queue with out_ready=0 forces imem_req=0; simultaneous pop and write on a full queue SHALL keep occupancy DEPTH.
REQ-022 SHALL, on redirect=1: complete any pop in the same cycle, then empty the queue, discard the in-flight response, load fetch PC with redirect_pc; imem_req SHALL be 0 that cycle and 1 at redirect_pc the next cycle.
REQ-023 SHALL give redirect priority over write; back-to-back redirects SHALL each restart fetch, last one wins.
REQ-024 SHALL wrap internal read/write pointers modulo DEPTH with no bubble at wrap.

Reset
REQ-025 SHALL, while reset=0, asynchronously force imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_fault=0, occupancy=0, in-flight=0.
REQ-026 SHALL issue first request at RESET_PC in the first cycle after reset rises; reset asserted mid-operation SHALL discard all queued and in-flight data.

Configuration
REQ-027 SHALL, with FETCH_MISALIGN_TRAP_EN defined, on redirect with redirect_pc[1:0]!=0 set fetch_fault=1, flush, stop requests until next aligned redirect or reset (which clears fetch_fault).
REQ-028 SHALL, without FETCH_MISALIGN_TRAP_EN, hold fetch_fault=0 and use {redirect_pc[31:2],2'b00}.

Verification
REQ-029 Reset release, memory[0]=ADDI x5,x0,3 (32'h00300293), out_ready=1 -> imem_req at addr 0 cycle 1, out_valid with out_pc=0, out_instr=32'h00300293 cycle 3.
REQ-030 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries (pc 0,4,8,12), imem_req=0 afterwards; out_ready=1 -> pops 0,4,8,12,16 on consecutive cycles.
REQ-031 Redirect to 32'h40 while pc 8 in flight and queue holds 0,4 -> pcs 0,4,8 never output after redirect; next out_pc=32'h40.
REQ-032 Redirect coincident with pop of pc 0 -> pc 0 consumed once, next out_pc=redirect_pc.
REQ-033 Macro defined, redirect_pc=32'h42 -> fetch_fault=1, imem_req=0; redirect to 32'h80 -> fault cleared, fetch resumes at 32'h80. Macro undefined -> fetch at 32'h40, fetch_fault=0.
REQ-034 reset=0 pulse mid-stream with full queue -> outputs zero immediately, refetch from RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers returned words, and flushes on redirect.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (fault on misaligned redirect and stall fetch).
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        fetch_fault
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [XLEN-1:0]  mem_instr [DEPTH];
    logic [XLEN-1:0]  mem_pc    [DEPTH];

    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CNT_W-1:0] occ_after_pop;
    logic             inflight, inflight_n;
    logic [XLEN-1:0]  inflight_pc, inflight_pc_n;
    logic [XLEN-1:0]  fetch_pc, fetch_pc_n;
    logic             fault_n;
    logic             out_valid_n;
    logic [XLEN-1:0]  out_instr_n, out_pc_n;
    logic             pop;
    logic             wr_en;

    assign imem_addr = fetch_pc;
    assign pop       = out_valid & out_ready;
    assign wr_en     = inflight & ~redirect;

    // Request whenever the response is guaranteed a free slot; redirect cycles never fetch.
    assign imem_req  = reset & ~fetch_fault & ~redirect &
                       ((SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH));

    always_comb begin
        rd_ptr_n      = rd_ptr;
        wr_ptr_n      = wr_ptr;
        count_n       = count;
        inflight_n    = inflight;
        inflight_pc_n = inflight_pc;
        fetch_pc_n    = fetch_pc;
        fault_n       = fetch_fault;
        out_valid_n   = out_valid;
        out_instr_n   = out_instr;
        out_pc_n      = out_pc;
        occ_after_pop = count - CNT_W'(pop);

        if (redirect) begin
            rd_ptr_n    = '0;
            wr_ptr_n    = '0;
            count_n     = '0;
            inflight_n  = 1'b0;
            out_valid_n = 1'b0;
            fetch_pc_n  = redirect_pc & ALIGN_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_n     = (redirect_pc[1:0] != 2'b00);
`else
            fault_n     = 1'b0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            if (wr_en) begin
                wr_ptr_n = wr_ptr + PTR_W'(1);
            end
            count_n       = occ_after_pop + CNT_W'(wr_en);
            inflight_n    = imem_req;
            inflight_pc_n = fetch_pc;
            if (imem_req) begin
                fetch_pc_n = fetch_pc + XLEN'(4);
            end
            // Next head comes from storage, or straight from the write when the queue drains.
            if (occ_after_pop != '0) begin
                out_valid_n = 1'b1;
                out_instr_n = mem_instr[rd_ptr_n];
                out_pc_n    = mem_pc[rd_ptr_n];
            end else if (wr_en) begin
                out_valid_n = 1'b1;
                out_instr_n = imem_rdata;
                out_pc_n    = inflight_pc;
            end else begin
                out_valid_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fetch_pc    <= RESET_PC;
            fetch_fault <= 1'b0;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
        end else begin
            rd_ptr      <= rd_ptr_n;
            wr_ptr      <= wr_ptr_n;
            count       <= count_n;
            inflight    <= inflight_n;
            inflight_pc <= inflight_pc_n;
            fetch_pc    <= fetch_pc_n;
            fetch_fault <= fault_n;
            out_valid   <= out_valid_n;
            out_instr   <= out_instr_n;
            out_pc      <= out_pc_n;
        end
    end

    // Queue storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]    <= inflight_pc;
        end
    end

endmodule
